// File: rtl/branch_pkg.sv
// Shared types for the branch controller: opcode fields, condition codes,
// the two-state squash machine and the {N,Z,V,C} flags record.
package branch_pkg;

  localparam logic [5:0] OP_B     = 6'b000101;
  localparam logic [5:0] OP_BL    = 6'b100101;
  localparam logic [7:0] OP_CBZ   = 8'b10110100;
  localparam logic [7:0] OP_CBNZ  = 8'b10110101;
  localparam logic [7:0] OP_BCOND = 8'b01010100;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  // Packed with n as the MSB so the struct reads directly as {N,Z,V,C}.
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// Pipeline-side bundle for branch_ctrl: decode inputs, ALU flags and the
// program-counter control outputs. master = datapath, slave = branch_ctrl.
interface branch_ctrl_if;

  logic [31:0] instr;
  logic        instr_valid;
  logic        rt_zero;
  logic        alu_negative;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_carry_out;
  logic        flag_we;
  logic [18:0] cond_addr;
  logic [25:0] br_addr;
  logic        uncondbr;
  logic        br_taken;
  logic        squash;
  logic [3:0]  flags;

  modport master (
    output instr, instr_valid, rt_zero,
    output alu_negative, alu_zero, alu_overflow, alu_carry_out, flag_we,
    input  cond_addr, br_addr, uncondbr, br_taken, squash, flags
  );

  modport slave (
    input  instr, instr_valid, rt_zero,
    input  alu_negative, alu_zero, alu_overflow, alu_carry_out, flag_we,
    output cond_addr, br_addr, uncondbr, br_taken, squash, flags
  );

endinterface

// File: rtl/cond_eval.sv
// Purely combinational evaluation of a 4-bit B.cond condition code against
// a set of {N,Z,V,C} flags.
module cond_eval
  import branch_pkg::*;
(
  input  flags_t     flags,
  input  logic [3:0] cond,
  output logic       taken
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case so no path leaves it unassigned (which would infer a latch).
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ: taken = flags.z;
      COND_NE: taken = !flags.z;
      COND_HS: taken = flags.c;
      COND_LO: taken = !flags.c;
      COND_MI: taken = flags.n;
      COND_PL: taken = !flags.n;
      COND_VS: taken = flags.v;
      COND_VC: taken = !flags.v;
      COND_HI: taken = flags.c && !flags.z;
      COND_LS: taken = !flags.c || flags.z;
      COND_GE: taken = (flags.n == flags.v);
      COND_LT: taken = (flags.n != flags.v);
      COND_GT: taken = !flags.z && (flags.n == flags.v);
      COND_LE: taken = flags.z || (flags.n != flags.v);
      COND_AL,
      COND_NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch decode, flags register and one-cycle squash FSM for a single-issue
// pipeline. Define BRANCH_FLAG_FWD_EN to let B.cond see same-cycle ALU flags.
module branch_ctrl
  import branch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  branch_ctrl_if.slave    bus
);

  state_e state;
  flags_t flags_q;
  flags_t flags_live;
  flags_t flags_eff;
  logic   is_b;
  logic   is_cbz;
  logic   is_cbnz;
  logic   is_bcond;
  logic   cond_taken;
  logic   raw_taken;
  logic   br_taken;
  logic   uncondbr;

  assign flags_live = '{n: bus.alu_negative, z: bus.alu_zero,
                        v: bus.alu_overflow, c: bus.alu_carry_out};

`ifdef BRANCH_FLAG_FWD_EN
  assign flags_eff = bus.flag_we ? flags_live : flags_q;
`else
  assign flags_eff = flags_q;
`endif

  cond_eval u_cond_eval (
    .flags (flags_eff),
    .cond  (bus.instr[3:0]),
    .taken (cond_taken)
  );

  always_comb begin
    is_b     = (bus.instr[31:26] == OP_B) || (bus.instr[31:26] == OP_BL);
    is_cbz   = (bus.instr[31:24] == OP_CBZ);
    is_cbnz  = (bus.instr[31:24] == OP_CBNZ);
    is_bcond = (bus.instr[31:24] == OP_BCOND) && !bus.instr[4];

    raw_taken = 1'b0;
    if (is_b)          raw_taken = 1'b1;
    else if (is_cbz)   raw_taken = bus.rt_zero;
    else if (is_cbnz)  raw_taken = !bus.rt_zero;
    else if (is_bcond) raw_taken = cond_taken;

    // The slot after a taken branch is a wrong-path fetch, so it may never
    // redirect the PC itself.
    br_taken = reset && bus.instr_valid && (state == ST_RUN) && raw_taken;
    uncondbr = reset && bus.instr_valid && is_b;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state   <= ST_RUN;
      flags_q <= '0;
    end else begin
      if (bus.flag_we)
        flags_q <= flags_live;
      case (state)
        ST_RUN:    state <= br_taken ? ST_SQUASH : ST_RUN;
        ST_SQUASH: state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase
    end
  end

  assign bus.cond_addr = bus.instr[23:5];
  assign bus.br_addr   = bus.instr[25:0];
  assign bus.uncondbr  = uncondbr;
  assign bus.br_taken  = br_taken;
  assign bus.squash    = reset && (state == ST_SQUASH);
  assign bus.flags     = flags_q;

endmodule
